// File: rtl/lsu_pkg.sv
// Shared definitions for the load-store unit: funct3 encodings, FSM states,
// MMIO window constants and the fault/load-format helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [23:0] MMIO_BASE     = 24'h000070;
  localparam logic [7:0]  MMIO_LEDR_OFF = 8'h00;
  localparam logic [7:0]  MMIO_SW_OFF   = 8'h10;

  typedef enum logic [1:0] {IDLE, LOAD, RESP} lsu_state_e;

  // Illegal size/sign encoding for the direction, or a misaligned half/word.
  function automatic logic is_fault(input logic st, input logic [2:0] f3,
                                    input logic [1:0] a);
    logic badF3;
    logic misal;
    badF3 = st ? (f3 > F3_W) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    misal = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    return badF3 || misal;
  endfunction

  // Pick the addressed lane out of a raw word and sign/zero extend it.
  function automatic logic [31:0] load_format(input logic [2:0] f3,
                                              input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (f3)
      F3_B:    return {{24{sh[7]}}, sh[7:0]};
      F3_BU:   return {24'h0, sh[7:0]};
      F3_H:    return {{16{sh[15]}}, sh[15:0]};
      F3_HU:   return {16'h0, sh[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Private data memory: 2^AW x 32 synchronous-read RAM with byte-enabled write.
module lsu_dmem #(
  parameter int AW = 11
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [2**AW];
  logic [31:0] rdata_q;

  // Byte-lane writes and a registered read; contents are never cleared.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lsu.sv
// Load-store unit: RV32I loads/stores on a private data memory with a
// req/ready/done handshake. Optional MMIO window (LEDR/SW) under LSU_MMIO_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int DMEM_AW = 11
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic        o_ready,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_ld_data,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_io_ledr
);

  lsu_state_e  state_q, state_d;
  logic        err_q, err_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic [31:0] ledr_q, ledr_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic        io_q, io_d;
  logic [7:0]  off_q, off_d;

  logic        fault, isIo, memWe, memRe;
  logic [3:0]  be;
  logic [31:0] wdata, memRdata, swVal, ioRdata, raw;
  logic        unused;

`ifdef LSU_MMIO_EN
  assign isIo  = (i_addr[31:8] == MMIO_BASE);
  assign swVal = i_io_sw;
`else
  assign isIo  = 1'b0;
  assign swVal = 32'h0;
`endif

  assign unused = ^{i_io_sw, i_addr};

  assign fault = is_fault(i_is_store, i_funct3, i_addr[1:0]);

  // Replicate store data across lanes; byte-enables pick the addressed lane.
  always_comb begin
    wdata = i_st_data;
    be    = 4'b1111;
    case (i_funct3[1:0])
      2'b00: begin
        wdata = {4{i_st_data[7:0]}};
        be    = 4'b0001 << i_addr[1:0];
      end
      2'b01: begin
        wdata = {2{i_st_data[15:0]}};
        be    = i_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Raw word returned in LOAD: memory, or the IO register picked at accept.
  always_comb begin
    ioRdata = 32'h0;
    if (off_q == MMIO_SW_OFF)        ioRdata = swVal;
    else if (off_q == MMIO_LEDR_OFF) ioRdata = ledr_q;
    raw = io_q ? ioRdata : memRdata;
  end

  // Next-state logic: accept in IDLE, format in LOAD, pulse done in RESP.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    ld_data_d = ld_data_q;
    ledr_d    = ledr_q;
    f3_d      = f3_q;
    lane_d    = lane_q;
    io_d      = io_q;
    off_d     = off_q;
    memWe     = 1'b0;
    memRe     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          f3_d    = i_funct3;
          lane_d  = i_addr[1:0];
          io_d    = isIo;
          off_d   = i_addr[7:0];
          err_d   = fault;
          state_d = RESP;
          if (!fault) begin
            if (i_is_store) begin
              if (!isIo) begin
                memWe = 1'b1;
              end else if (i_addr[7:0] == MMIO_LEDR_OFF) begin
                for (int b = 0; b < 4; b++) begin
                  if (be[b]) ledr_d[8*b +: 8] = wdata[8*b +: 8];
                end
              end
            end else begin
              memRe   = !isIo;
              state_d = LOAD;
            end
          end
        end
      end
      LOAD: begin
        ld_data_d = load_format(f3_q, lane_q, raw);
        state_d   = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and context registers; async reset drops any in-flight access.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      err_q     <= 1'b0;
      ld_data_q <= 32'h0;
      ledr_q    <= 32'h0;
      f3_q      <= 3'b0;
      lane_q    <= 2'b0;
      io_q      <= 1'b0;
      off_q     <= 8'h0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      ld_data_q <= ld_data_d;
      ledr_q    <= ledr_d;
      f3_q      <= f3_d;
      lane_q    <= lane_d;
      io_q      <= io_d;
      off_q     <= off_d;
    end
  end

  lsu_dmem #(.AW(DMEM_AW)) u_dmem (
    .clk_i   (i_clk),
    .we_i    (memWe),
    .re_i    (memRe),
    .be_i    (be),
    .addr_i  (i_addr[DMEM_AW+1:2]),
    .wdata_i (wdata),
    .rdata_o (memRdata)
  );

  assign o_ready   = (state_q == IDLE);
  assign o_done    = (state_q == RESP);
  assign o_err     = err_q;
  assign o_ld_data = ld_data_q;
  assign o_io_ledr = ledr_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: requests push expected responses, a monitor pops
// and compares them whenever o_done fires.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rstN;
  logic        req, isStore;
  logic [2:0]  funct3;
  logic [31:0] addr, stData, ioSw;
  logic        ready, done, err;
  logic [31:0] ldData, ioLedr;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] data;
    int          issue;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  lsu dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_req      (req),
    .i_is_store (isStore),
    .i_funct3   (funct3),
    .i_addr     (addr),
    .i_st_data  (stData),
    .o_ready    (ready),
    .o_done     (done),
    .o_err      (err),
    .o_ld_data  (ldData),
    .i_io_sw    (ioSw),
    .o_io_ledr  (ioLedr)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rstN && done) begin
      if (sbq.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_done: got done with empty scoreboard expected none");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checkOutput({e.name, "_err"}, {31'b0, err}, {31'b0, e.err});
        checkOutput({e.name, "_data"}, ldData, e.data);
        checkOutput({e.name, "_lat"}, cyc - e.issue, e.lat);
      end
    end
  end

  // Issue one request, push its expectation, and wait for the unit to idle.
  task automatic applyStimulus(input string name, input bit st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] d,
                               input bit expErr, input logic [31:0] expData,
                               input int lat, input bit hold);
    exp_t e;
    int n;
    @(negedge clk);
    req = 1'b1; isStore = st; funct3 = f3; addr = a; stData = d;
    e.name = name; e.err = expErr; e.data = expData; e.issue = cyc; e.lat = lat;
    sbq.push_back(e);
    @(negedge clk);
    if (hold) begin
      isStore = 1'b1; funct3 = 3'b010; addr = 32'h100; stData = 32'h0;
      @(negedge clk);
    end
    req = 1'b0;
    n = 0;
    while (!ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!ready) checkOutput({name, "_timeout"}, {31'b0, ready}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rstN = 1'b0; req = 1'b0; isStore = 1'b0; funct3 = 3'b0;
    addr = 32'h0; stData = 32'h0; ioSw = 32'h0;
    #12;
    checkOutput("rst_ready", {31'b0, ready}, 32'h1);
    checkOutput("rst_done",  {31'b0, done},  32'h0);
    checkOutput("rst_err",   {31'b0, err},   32'h0);
    checkOutput("rst_ld",    ldData,         32'h0);
    checkOutput("rst_ledr",  ioLedr,         32'h0);
    @(negedge clk);
    rstN = 1'b1;

    applyStimulus("sw100",  1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0,        1, 0);
    applyStimulus("lw100",  0, 3'b010, 32'h100, 32'h0,        0, 32'hDEADBEEF, 2, 0);
    applyStimulus("sw200",  1, 3'b010, 32'h200, 32'h0,        0, 32'hDEADBEEF, 1, 0);
    applyStimulus("sb203",  1, 3'b000, 32'h203, 32'h000000A5, 0, 32'hDEADBEEF, 1, 0);
    applyStimulus("lb203",  0, 3'b000, 32'h203, 32'h0,        0, 32'hFFFFFFA5, 2, 0);
    applyStimulus("lbu203", 0, 3'b100, 32'h203, 32'h0,        0, 32'h000000A5, 2, 0);
    applyStimulus("lw200",  0, 3'b010, 32'h200, 32'h0,        0, 32'hA5000000, 2, 0);
    applyStimulus("sw300",  1, 3'b010, 32'h300, 32'h0,        0, 32'hA5000000, 1, 0);
    applyStimulus("sh302",  1, 3'b001, 32'h302, 32'h00008001, 0, 32'hA5000000, 1, 0);
    applyStimulus("lh302",  0, 3'b001, 32'h302, 32'h0,        0, 32'hFFFF8001, 2, 0);
    applyStimulus("lhu302", 0, 3'b101, 32'h302, 32'h0,        0, 32'h00008001, 2, 0);
    applyStimulus("lh301",  0, 3'b001, 32'h301, 32'h0,        1, 32'h00008001, 1, 0);
    applyStimulus("lw300",  0, 3'b010, 32'h300, 32'h0,        0, 32'h80010000, 2, 0);
    applyStimulus("sw102",  1, 3'b010, 32'h102, 32'h11111111, 1, 32'h80010000, 1, 0);
    applyStimulus("lwhold", 0, 3'b010, 32'h100, 32'h0,        0, 32'hDEADBEEF, 2, 1);
    applyStimulus("ld011",  0, 3'b011, 32'h100, 32'h0,        1, 32'hDEADBEEF, 1, 0);
    applyStimulus("st100",  1, 3'b100, 32'h100, 32'h0,        1, 32'hDEADBEEF, 1, 0);
    applyStimulus("lwchk",  0, 3'b010, 32'h100, 32'h0,        0, 32'hDEADBEEF, 2, 0);

`ifdef LSU_MMIO_EN
    applyStimulus("swledr", 1, 3'b010, 32'h7000, 32'h000000FF, 0, 32'hDEADBEEF, 1, 0);
    checkOutput("ledr_val", ioLedr, 32'h000000FF);
    ioSw = 32'h12345678;
    applyStimulus("lwsw",   0, 3'b010, 32'h7010, 32'h0,        0, 32'h12345678, 2, 0);
    applyStimulus("lbu7001",0, 3'b100, 32'h7001, 32'h0,        0, 32'h00000000, 2, 0);
    applyStimulus("lwledr", 0, 3'b010, 32'h7000, 32'h0,        0, 32'h000000FF, 2, 0);
`else
    applyStimulus("sw7000", 1, 3'b010, 32'h7000, 32'h000000FF, 0, 32'hDEADBEEF, 1, 0);
    checkOutput("ledr_tied", ioLedr, 32'h0);
    applyStimulus("lw7000", 0, 3'b010, 32'h7000, 32'h0,        0, 32'h000000FF, 2, 0);
`endif

    // Reset in the middle of a load: no scoreboard entry, done must never come.
    @(negedge clk);
    req = 1'b1; isStore = 1'b0; funct3 = 3'b010; addr = 32'h100;
    @(negedge clk);
    req = 1'b0;
    #1 rstN = 1'b0;
    #1;
    checkOutput("midrst_ready", {31'b0, ready}, 32'h1);
    checkOutput("midrst_done",  {31'b0, done},  32'h0);
    checkOutput("midrst_ld",    ldData,         32'h0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);

    applyStimulus("lwpost", 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 2, 0);
    repeat (3) @(negedge clk);
    checkOutput("sb_drain", sbq.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
